// File: rtl/mem_bus_responder_if.sv
// Request/response bus between an initiator (memory controller) and the RAM responder.
interface mem_bus_responder_if;
  logic        i_bus_en;
  logic        i_wr_en;
  logic [31:0] i_wr_data;
  logic [31:0] i_addr;
  logic [3:0]  i_byte_en;
  logic        o_ack;
  logic [31:0] o_rd_data;
  logic        o_err;

  modport master (
    output i_bus_en, i_wr_en, i_wr_data, i_addr, i_byte_en,
    input  o_ack, o_rd_data, o_err
  );

  modport slave (
    input  i_bus_en, i_wr_en, i_wr_data, i_addr, i_byte_en,
    output o_ack, o_rd_data, o_err
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Word-addressed scratch RAM responder with byte-enable writes and read-before-write data.
// Latency: ack in cycle LATENCY+1 after acceptance; at most one transaction per LATENCY+2 cycles.
// Backpressure: none; requests are sampled only in IDLE and the initiator holds i_bus_en until ack.
module mem_bus_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  mem_bus_responder_if.slave bus
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        wr_en;
    logic [31:0] wr_data;
    logic [29:0] word;
    logic [3:0]  byte_en;
  } req_t;

  state_t        state, state_nxt;
  req_t          req_q, req_in, req_cur;
  logic [3:0]    cnt_q;
  logic          access;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   old_word;
  logic [31:0]   mem [MEM_WORDS];
  logic          ack_q;
  logic          err_q;
  logic [31:0]   rd_q;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^bus.i_addr[1:0];

  always_comb begin
    req_in         = '0;
    req_in.wr_en   = bus.i_wr_en;
    req_in.wr_data = bus.i_wr_data;
    req_in.word    = bus.i_addr[31:2];
    req_in.byte_en = bus.i_byte_en;
  end

  // With zero wait states the access happens on the acceptance edge, before req_q is loaded.
  assign req_cur  = (state == IDLE) ? req_in : req_q;
  assign in_range = (32'(req_cur.word) < 32'(MEM_WORDS));
  assign idx      = req_cur.word[AW-1:0];
  assign old_word = mem[idx];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_bus_en) state_nxt = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt_q == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The RAM access completes on the edge that enters RESP; reset suppresses it.
  assign access = (state_nxt == RESP) && i_rst;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
      req_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rd_q  <= '0;
    end else begin
      if (state == IDLE && bus.i_bus_en) begin
        req_q <= req_in;
        cnt_q <= 4'(LATENCY);
      end else if (state == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      ack_q <= access;
      err_q <= access && !in_range;
      if (access) rd_q <= in_range ? old_word : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (access && req_cur.wr_en && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (req_cur.byte_en[b]) mem[idx][8*b +: 8] <= req_cur.wr_data[8*b +: 8];
      end
    end
  end

  assign bus.o_ack     = ack_q;
  assign bus.o_err     = err_q;
  assign bus.o_rd_data = rd_q;
endmodule

// File: tb/tb_mem_bus_responder.sv
// Three responders (LATENCY 2/0/3, depth 1024/1024/64) checked against a word-map reference model.
module tb_mem_bus_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  bus_en;
  logic [2:0]  wr_en;
  logic [31:0] wr_data [3];
  logic [31:0] addr    [3];
  logic [3:0]  byte_en [3];
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [31:0] rd_data [3];

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [longint];

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] a;
    logic [31:0] dat;
    logic [3:0]  be;
    bit          ab;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_bus_responder_if bus ();
    assign bus.i_bus_en  = bus_en[g];
    assign bus.i_wr_en   = wr_en[g];
    assign bus.i_wr_data = wr_data[g];
    assign bus.i_addr    = addr[g];
    assign bus.i_byte_en = byte_en[g];
    assign ack[g]        = bus.o_ack;
    assign err[g]        = bus.o_err;
    assign rd_data[g]    = bus.o_rd_data;

    mem_bus_responder #(
      .MEM_WORDS((g == 2) ? 64 : 1024),
      .LATENCY  ((g == 0) ? 2 : ((g == 1) ? 0 : 3))
    ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 3);
  endfunction

  function automatic int words_of(input int d);
    return (d == 2) ? 64 : 1024;
  endfunction

  function automatic longint key_of(input int d, input logic [31:0] a);
    return longint'(d) * 64'sh1_0000_0000 + longint'(a >> 2);
  endfunction

  function automatic bit in_range(input int d, input logic [31:0] a);
    return (a >> 2) < 32'(words_of(d));
  endfunction

  function automatic void mdl_write(input int d, input logic [31:0] a, input logic [31:0] dat,
                                    input logic [3:0] be);
    logic [31:0] mask;
    longint      k;
    if (!in_range(d, a)) return;
    k    = key_of(d, a);
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    if (mdl.exists(k))   mdl[k] = (mdl[k] & ~mask) | (dat & mask);
    else if (be == 4'hF) mdl[k] = dat;
  endfunction

  function automatic void add(input int d, input bit wr, input logic [31:0] a, input logic [31:0] dat,
                              input logic [3:0] be, input bit ab, input bit chk_rd,
                              input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.d = d; v.wr = wr; v.a = a; v.dat = dat; v.be = be; v.ab = ab;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called mid-cycle; lat is the cycle of the ack counted from the acceptance cycle (0), -1 if none.
  task automatic txn(input int d, input bit wr, input logic [31:0] a, input logic [31:0] dat,
                     input logic [3:0] be, input bit ab,
                     output logic [31:0] rd, output logic er, output int lat);
    bus_en[d] = 1'b1; wr_en[d] = wr; addr[d] = a; wr_data[d] = dat; byte_en[d] = be;
    lat = -1; rd = '0; er = 1'b0;
    chk($sformatf("dut%0d ack low in acceptance cycle", d), 32'(ack[d]), 32'd0);
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      cyc();
      if (c == 1) begin
        if (ab) bus_en[d] = 1'b0;
        wr_en[d]   = 1'($urandom);
        addr[d]    = $urandom;
        wr_data[d] = $urandom;
        byte_en[d] = 4'($urandom);
      end
      if (ack[d]) begin
        lat = c; rd = rd_data[d]; er = err[d];
      end
    end
    cyc();
    bus_en[d] = 1'b0;
    if (lat >= 0) begin
      chk($sformatf("dut%0d ack single pulse", d), 32'(ack[d]), 32'd0);
      chk($sformatf("dut%0d rd_data held", d), rd_data[d], rd);
    end
  endtask

  task automatic mtxn(input int d, input bit wr, input logic [31:0] a, input logic [31:0] dat,
                      input logic [3:0] be, input bit ab);
    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          inr;
    bit          known;
    logic [31:0] exp_rd;
    inr    = in_range(d, a);
    known  = !inr || mdl.exists(key_of(d, a));
    exp_rd = (inr && known) ? mdl[key_of(d, a)] : 32'd0;
    txn(d, wr, a, dat, be, ab, rd, er, lat);
    chk($sformatf("dut%0d addr %h latency", d, a), 32'(lat), 32'(lat_of(d) + 1));
    chk($sformatf("dut%0d addr %h err", d, a), 32'(er), 32'(!inr));
    if (known) chk($sformatf("dut%0d addr %h rd_data", d, a), rd, exp_rd);
    if (wr) mdl_write(d, a, dat, be);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          seen;

    rst = 1'b0;
    bus_en = '0; wr_en = '0;
    for (int d = 0; d < 3; d++) begin
      wr_data[d] = '0; addr[d] = '0; byte_en[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cyc();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("dut%0d reset ack", d), 32'(ack[d]), 32'd0);
      chk($sformatf("dut%0d reset err", d), 32'(err[d]), 32'd0);
      chk($sformatf("dut%0d reset rd_data", d), rd_data[d], 32'd0);
    end

    // Give every word the model uses a known value.
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 64; w++)
        mtxn(d, 1'b1, 32'(w * 4), $urandom, 4'hF, 1'b0);

    add(0, 1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 0, 32'h0,        0);
    add(0, 0, 32'h10,   32'h0,        4'h0, 0, 1, 32'hDEADBEEF, 0);
    add(0, 1, 32'h20,   32'hAABBCCDD, 4'hF, 0, 0, 32'h0,        0);
    add(0, 1, 32'h20,   32'h11223344, 4'h5, 0, 1, 32'hAABBCCDD, 0);
    add(0, 0, 32'h20,   32'h0,        4'h0, 0, 1, 32'hAA22CC44, 0);
    add(0, 1, 32'h0,    32'h12345678, 4'hF, 0, 0, 32'h0,        0);
    add(0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, 1, 32'h0,        1);
    add(0, 0, 32'h1003, 32'h0,        4'h0, 0, 1, 32'h0,        1);
    add(0, 0, 32'h0,    32'h0,        4'h0, 0, 1, 32'h12345678, 0);
    add(2, 1, 32'h30,   32'h0,        4'hF, 0, 0, 32'h0,        0);
    add(2, 1, 32'h30,   32'hCAFEF00D, 4'hF, 1, 1, 32'h0,        0);
    add(2, 0, 32'h30,   32'h0,        4'h0, 0, 1, 32'hCAFEF00D, 0);
    add(2, 1, 32'h30,   32'h55555555, 4'h0, 0, 1, 32'hCAFEF00D, 0);
    add(2, 0, 32'h31,   32'h0,        4'h0, 0, 1, 32'hCAFEF00D, 0);
    add(2, 1, 32'hFC,   32'h0BADF00D, 4'hF, 0, 0, 32'h0,        0);
    add(2, 0, 32'hFC,   32'h0,        4'h0, 0, 1, 32'h0BADF00D, 0);
    add(2, 0, 32'h100,  32'h0,        4'h0, 0, 1, 32'h0,        1);

    foreach (vecs[i]) begin
      txn(vecs[i].d, vecs[i].wr, vecs[i].a, vecs[i].dat, vecs[i].be, vecs[i].ab, rd, er, lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(lat_of(vecs[i].d) + 1));
      chk($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
      if (vecs[i].chk_rd) chk($sformatf("vec%0d rd_data", i), rd, vecs[i].exp_rd);
      if (vecs[i].wr) mdl_write(vecs[i].d, vecs[i].a, vecs[i].dat, vecs[i].be);
    end

    // Reset while a write waits: the write is dropped and no ack appears.
    mtxn(0, 1'b1, 32'h50, 32'h01010101, 4'hF, 1'b0);
    bus_en[0] = 1'b1; wr_en[0] = 1'b1; addr[0] = 32'h50; wr_data[0] = 32'h99999999; byte_en[0] = 4'hF;
    cyc();
    rst = 1'b0;
    #1;
    chk("reset mid-wait ack", 32'(ack[0]), 32'd0);
    chk("reset mid-wait err", 32'(err[0]), 32'd0);
    chk("reset mid-wait rd_data", rd_data[0], 32'd0);
    bus_en[0] = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      if (ack[0]) seen++;
    end
    chk("no ack after reset", 32'(seen), 32'd0);
    txn(0, 1'b0, 32'h50, 32'h0, 4'h0, 1'b0, rd, er, lat);
    chk("dropped write not visible", rd, 32'h01010101);

    // AMO pattern with zero wait states: read, one idle cycle, write, then back-to-back reads.
    mtxn(1, 1'b1, 32'h40, 32'd5, 4'hF, 1'b0);
    txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, rd, er, lat);
    chk("amo read latency", 32'(lat), 32'd1);
    chk("amo read data", rd, 32'd5);
    cyc();
    txn(1, 1'b1, 32'h40, 32'd7, 4'hF, 1'b0, rd, er, lat);
    chk("amo write latency", 32'(lat), 32'd1);
    chk("amo write old data", rd, 32'd5);
    mdl_write(1, 32'h40, 32'd7, 4'hF);
    txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, rd, er, lat);
    chk("amo readback", rd, 32'd7);
    txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, rd, er, lat);
    chk("back-to-back latency", 32'(lat), 32'd1);

    for (int n = 0; n < 200; n++) begin
      int          d;
      int          r;
      logic [31:0] a;
      d = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'((words_of(d) + $urandom_range(0, 7)) * 4 + $urandom_range(0, 3));
      else if (r == 1) a = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
      else             a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      mtxn(d, 1'($urandom), a, $urandom, 4'($urandom), ($urandom_range(0, 5) == 0));
      repeat ($urandom_range(0, 2)) cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
